// File: rtl/mole_game_fsm.sv
// ByteBasher game controller: spawns one target at a time at a pseudo-random
// pad, times its visible window, judges hits and keeps a BCD score plus a
// saturating miss tally. Holds the round counter in reset outside active play.
//
// Input protocol: Start and hit_valid are single-cycle pulses sampled on the
// rising edge of ClockIn; hit_pos is meaningful only while hit_valid is high.
// There is no backpressure: every pulse is either consumed in the state that
// accepts it or dropped.
module mole_game_fsm #(
    parameter int          MOLE_CYCLES = 25000000,
    parameter int          GAP_CYCLES  = 12500000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       Start,
    input  logic       game_done,
    input  logic       hit_valid,
    input  logic [1:0] hit_pos,
    output logic       timer_reset,
    output logic       mole_active,
    output logic [1:0] mole_pos,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic [3:0] miss_count,
    output logic       game_over
);

    // One counter serves both the visible window and the inter-target gap.
    localparam int MAX_CYCLES = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MOLE_LOAD = CNT_W'(MOLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SPAWN = 3'd1,
        S_WAIT  = 3'd2,
        S_HIT   = 3'd3,
        S_MISS  = 3'd4,
        S_GAP   = 3'd5,
        S_OVER  = 3'd6
    } state_t;

    // Current FSM state; named so checkers can bind to it hierarchically.
    state_t state;
    state_t state_next;

    logic [7:0]       lfsr;
    logic             lfsr_fb;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       spawn_pos;

    logic clear_game;
    logic load_pos;
    logic load_mole;
    logic load_gap;
    logic dec_cnt;
    logic inc_score;
    logic inc_miss;

    // Taps 8,6,5,4 of a Fibonacci LFSR shifting toward the MSB.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Avoid showing the same pad twice in a row by nudging the candidate up one.
    assign spawn_pos = (lfsr[1:0] == mole_pos) ? (lfsr[1:0] + 2'd1) : lfsr[1:0];

    // State register.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control; game_done preempts every in-play action.
    always_comb begin
        state_next = state;
        clear_game = 1'b0;
        load_pos   = 1'b0;
        load_mole  = 1'b0;
        load_gap   = 1'b0;
        dec_cnt    = 1'b0;
        inc_score  = 1'b0;
        inc_miss   = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                if (Start) begin
                    clear_game = 1'b1;
                    state_next = S_SPAWN;
                end
            end
            S_SPAWN: begin
                if (game_done) begin
                    state_next = S_OVER;
                end else begin
                    load_pos   = 1'b1;
                    load_mole  = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (game_done) begin
                    state_next = S_OVER;
                end else if (hit_valid && (hit_pos == mole_pos)) begin
                    state_next = S_HIT;
                end else begin
                    inc_miss = hit_valid;
                    if (cnt == '0) begin
                        state_next = S_MISS;
                    end else begin
                        dec_cnt = 1'b1;
                    end
                end
            end
            S_HIT: begin
                if (game_done) begin
                    state_next = S_OVER;
                end else begin
                    inc_score  = 1'b1;
                    load_gap   = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_MISS: begin
                if (game_done) begin
                    state_next = S_OVER;
                end else begin
                    inc_miss   = 1'b1;
                    load_gap   = 1'b1;
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (game_done) begin
                    state_next = S_OVER;
                end else if (cnt == '0) begin
                    state_next = S_SPAWN;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // LFSR, window/gap counter, target position, score and miss tally.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            lfsr       <= LFSR_SEED;
            cnt        <= '0;
            mole_pos   <= 2'd0;
            score_ones <= 4'd0;
            score_tens <= 4'd0;
            miss_count <= 4'd0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};

            if (load_mole) begin
                cnt <= MOLE_LOAD;
            end else if (load_gap) begin
                cnt <= GAP_LOAD;
            end else if (dec_cnt) begin
                cnt <= cnt - 1'b1;
            end

            if (clear_game) begin
                mole_pos <= 2'd0;
            end else if (load_pos) begin
                mole_pos <= spawn_pos;
            end

            if (clear_game) begin
                score_ones <= 4'd0;
                score_tens <= 4'd0;
            end else if (inc_score && !((score_tens == 4'd9) && (score_ones == 4'd9))) begin
                if (score_ones == 4'd9) begin
                    score_ones <= 4'd0;
                    score_tens <= score_tens + 4'd1;
                end else begin
                    score_ones <= score_ones + 4'd1;
                end
            end

            if (clear_game) begin
                miss_count <= 4'd0;
            end else if (inc_miss && (miss_count != 4'd15)) begin
                miss_count <= miss_count + 4'd1;
            end
        end
    end

    // Status outputs decoded straight from the state register.
    assign timer_reset = (state == S_IDLE) || (state == S_OVER);
    assign mole_active = (state == S_WAIT);
    assign game_over   = (state == S_OVER);

endmodule

// File: doc/mole_game_fsm.md
Name: mole_game_fsm

Overview:
- Game-control FSM for ByteBasher, directly downstream of the game countdown counter.
- Consumes the counter's `done` flag. Drives the counter's reset, so the round timer is held at 00 until play starts.
- Spawns one "byte" target at a pseudo-random position, times its visible window and judges hits.
- Keeps a 2-digit BCD score and a miss tally; the score feeds the existing 7-segment hex decoders.

Parameters:
- MOLE_CYCLES, 25000000: clock cycles a target stays visible (0.5 s at 50 MHz); must be ≥2.
- GAP_CYCLES, 12500000: idle clock cycles between targets; must be ≥1.
- LFSR_SEED, 8'hA5: LFSR value loaded on reset; must be non-zero.

Ports:
- ClockIn  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- Start  in  1  one-cycle pulse; begins a game from IDLE or OVER
- game_done  in  1  `done` from the round counter (high while timer reads 99)
- hit_valid  in  1  one-cycle pulse, already debounced upstream: player struck a pad
- hit_pos  in  2  pad index (0-3) qualified by hit_valid
- timer_reset  out  1  drives the round counter's Reset input
- mole_active  out  1  target currently visible
- mole_pos  out  2  index of the visible target
- score_ones  out  4  BCD ones digit of score
- score_tens  out  4  BCD tens digit of score
- miss_count  out  4  missed plus wrong hits, saturating at 15
- game_over  out  1  high in state OVER

Behaviour:
- Reset values:
  - state = IDLE; timer_reset = 1.
  - mole_active = 0, mole_pos = 0.
  - score = 00, miss_count = 0, game_over = 0.
  - lfsr = LFSR_SEED; window/gap counter = 0.
- All outputs are registered or decoded from registered state. Reset wins over every other input.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts every cycle in every state, including IDLE.
  - Candidate position = lfsr[1:0].
- States:
  - IDLE: timer_reset = 1, mole_active = 0.
    - Start → SPAWN; score, miss_count and prev_pos are cleared on the same edge.
  - SPAWN (1 cycle): load mole_pos.
    - Value = candidate, or (candidate+1) mod 4 if candidate equals the previous mole_pos (no back-to-back repeat). After reset, previous pos is treated as 0.
    - Load counter = MOLE_CYCLES-1 → WAIT.
  - WAIT: mole_active = 1; counter decrements each cycle.
    - hit_valid with hit_pos == mole_pos → HIT.
    - hit_valid with hit_pos != mole_pos → miss_count+1 (saturating); stay in WAIT; counter keeps running.
    - Counter == 0 with no matching hit → MISS.
    - A matching hit in the same cycle the counter reaches 0 counts as HIT.
  - HIT (1 cycle): score +1 in BCD (ones 9→0 carries into tens); saturates at 99, no wrap.
    - Load counter = GAP_CYCLES-1 → GAP.
  - MISS (1 cycle): miss_count+1 (saturating at 15).
    - Load counter = GAP_CYCLES-1 → GAP.
  - GAP: mole_active = 0; counter decrements; at 0 → SPAWN.
  - OVER: game_over = 1, timer_reset = 1, mole_active = 0.
    - Score and miss_count are frozen.
    - Start → SPAWN with score/miss_count cleared.
- Timing:
  - timer_reset = 0 in SPAWN, WAIT, HIT, MISS and GAP.
  - mole_active rises the cycle after SPAWN (first WAIT cycle) and falls the cycle after leaving WAIT.
- game_done:
  - In SPAWN/WAIT/HIT/MISS/GAP, game_done = 1 → OVER next cycle.
  - game_done has priority over a same-cycle hit/miss: that hit is not scored and HIT/MISS updates do not occur.
  - game_done is ignored in IDLE and OVER (counter is held in reset there).
- Other input rules:
  - Start is ignored outside IDLE/OVER.
  - hit_valid is ignored outside WAIT.

Test Plan (MOLE_CYCLES=8, GAP_CYCLES=4, LFSR_SEED=8'hA5):
- Reset 3 cycles, then idle 10 cycles → timer_reset=1, mole_active=0, score 0/0, miss_count=0, game_over=0 throughout.
- Start pulse; wait for mole_active; 2 cycles later pulse hit_valid with hit_pos=mole_pos → score_ones=1 after the HIT cycle; mole_active low for the 4-cycle GAP, then a new target with mole_pos ≠ previous.
- Never hit for 3 targets → each target visible exactly 8 cycles; miss_count=3; score stays 00. One wrong-pos hit mid-window → miss_count increments without ending the window.
- Force 99 matching hits → tens=9, ones=9; 100th hit leaves score at 9/9. Bench also checks the 9→10 carry: ones=0, tens=1.
- Assert game_done in the same cycle as a matching hit → next cycle state OVER: game_over=1, timer_reset=1, mole_active=0, score unchanged. Then Start → score 00, miss_count 0, SPAWN follows.
- Assert Reset mid-WAIT with score=05 → next cycle all outputs at reset values, state IDLE; Start pulse during WAIT has no effect.
